anabellek_hakemi: RTL and testbench

//  Shares the single main-memory port between the fetch-stage instruction cache controller (getir) and the

---
 rtl/anabellek_hakemi.sv | 173 +++++++++++++++++
 tb/tb_anabellek_hakemi.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anabellek_hakemi.sv
// Main-memory port arbiter between the fetch (getir) and data (bellek) cache controllers.
// One block transaction at a time: grant in BOSTA, one-cycle strobe in ISTEK, wait in BEKLE.
module anabellek_hakemi #(
  parameter int ADRES_BIT   = 32,
  parameter int OBEK_BIT    = 128,
  parameter bit ADIL        = 1'b1,
  parameter int ZAMAN_ASIMI = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 getir_istek_i,
  input  logic [ADRES_BIT-1:0] getir_adres_i,
  output logic                 getir_musait_o,
  output logic                 getir_veri_hazir_o,
  output logic [OBEK_BIT-1:0]  getir_obek_o,
  input  logic                 bellek_istek_i,
  input  logic                 bellek_yaz_i,
  input  logic [ADRES_BIT-1:0] bellek_adres_i,
  input  logic [OBEK_BIT-1:0]  bellek_yazilacak_obek_i,
  output logic                 bellek_musait_o,
  output logic                 bellek_veri_hazir_o,
  output logic [OBEK_BIT-1:0]  bellek_obek_o,
  input  logic                 anabellek_musait_i,
  input  logic                 anabellek_veri_hazir_i,
  input  logic [OBEK_BIT-1:0]  anabellek_obek_i,
  output logic                 anabellek_istek_o,
  output logic                 anabellek_oku_o,
  output logic                 anabellek_yaz_o,
  output logic [ADRES_BIT-1:0] anabellek_adres_o,
  output logic [OBEK_BIT-1:0]  anabellek_yazilacak_obek_o,
  output logic                 zaman_asimi_o
);

  localparam int SAYAC_BIT = $clog2(ZAMAN_ASIMI + 1);
  localparam logic [SAYAC_BIT-1:0] SINIR = SAYAC_BIT'(ZAMAN_ASIMI);

  typedef enum logic [1:0] {BOSTA, ISTEK, BEKLE} durum_e;

  durum_e                durum_q, durum_d;
  logic                  son_bellek_q, son_bellek_d;
  logic                  sahip_bellek_q, sahip_bellek_d;
  logic [SAYAC_BIT-1:0]  sayac_q, sayac_d;
  logic                  istek_q, istek_d;
  logic                  oku_q, oku_d;
  logic                  yaz_q, yaz_d;
  logic [ADRES_BIT-1:0]  adres_q, adres_d;
  logic [OBEK_BIT-1:0]   yobek_q, yobek_d;
  logic                  gvh_q, gvh_d;
  logic                  bvh_q, bvh_d;
  logic [OBEK_BIT-1:0]   gobek_q, gobek_d;
  logic [OBEK_BIT-1:0]   bobek_q, bobek_d;
  logic                  zaman_q, zaman_d;

  logic                  bellek_oncelikli;
  logic                  bellek_kazanir;
  logic                  kabul_edebilir;
  logic [SAYAC_BIT-1:0]  sayac_art;

  // On a tie bellek wins unless fairness is on and bellek was granted last.
  assign bellek_oncelikli = !ADIL || !son_bellek_q;
  assign bellek_kazanir   = bellek_istek_i && (!getir_istek_i || bellek_oncelikli);
  assign kabul_edebilir   = rst_i && (durum_q == BOSTA) && anabellek_musait_i;
  assign getir_musait_o   = kabul_edebilir && (!bellek_istek_i || !bellek_oncelikli);
  assign bellek_musait_o  = kabul_edebilir && (!getir_istek_i || bellek_oncelikli);
  assign sayac_art        = sayac_q + 1'b1;

  always_comb begin
    durum_d        = durum_q;
    son_bellek_d   = son_bellek_q;
    sahip_bellek_d = sahip_bellek_q;
    sayac_d        = sayac_q;
    istek_d        = 1'b0;
    oku_d          = oku_q;
    yaz_d          = yaz_q;
    adres_d        = adres_q;
    yobek_d        = yobek_q;
    gvh_d          = 1'b0;
    bvh_d          = 1'b0;
    gobek_d        = gobek_q;
    bobek_d        = bobek_q;
    zaman_d        = zaman_q;
    unique case (durum_q)
      BOSTA: begin
        if (anabellek_musait_i && (getir_istek_i || bellek_istek_i)) begin
          sahip_bellek_d = bellek_kazanir;
          son_bellek_d   = bellek_kazanir;
          adres_d        = bellek_kazanir ? bellek_adres_i : getir_adres_i;
          oku_d          = bellek_kazanir ? !bellek_yaz_i : 1'b1;
          yaz_d          = bellek_kazanir && bellek_yaz_i;
          yobek_d        = bellek_kazanir ? bellek_yazilacak_obek_i : '0;
          istek_d        = 1'b1;
          durum_d        = ISTEK;
        end
      end
      ISTEK: begin
        sayac_d = '0;
        durum_d = BEKLE;
      end
      BEKLE: begin
        // A response in the same cycle as the limit wins over the timeout.
        if (anabellek_veri_hazir_i) begin
          if (sahip_bellek_q) begin
            bvh_d   = 1'b1;
            bobek_d = anabellek_obek_i;
          end else begin
            gvh_d   = 1'b1;
            gobek_d = anabellek_obek_i;
          end
          durum_d = BOSTA;
        end else if (sayac_art == SINIR) begin
          if (sahip_bellek_q) begin
            bvh_d   = 1'b1;
            bobek_d = '0;
          end else begin
            gvh_d   = 1'b1;
            gobek_d = '0;
          end
          zaman_d = 1'b1;
          durum_d = BOSTA;
        end else begin
          sayac_d = sayac_art;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q        <= BOSTA;
      son_bellek_q   <= 1'b0;
      sahip_bellek_q <= 1'b0;
      sayac_q        <= '0;
      istek_q        <= 1'b0;
      oku_q          <= 1'b0;
      yaz_q          <= 1'b0;
      adres_q        <= '0;
      yobek_q        <= '0;
      gvh_q          <= 1'b0;
      bvh_q          <= 1'b0;
      gobek_q        <= '0;
      bobek_q        <= '0;
      zaman_q        <= 1'b0;
    end else begin
      durum_q        <= durum_d;
      son_bellek_q   <= son_bellek_d;
      sahip_bellek_q <= sahip_bellek_d;
      sayac_q        <= sayac_d;
      istek_q        <= istek_d;
      oku_q          <= oku_d;
      yaz_q          <= yaz_d;
      adres_q        <= adres_d;
      yobek_q        <= yobek_d;
      gvh_q          <= gvh_d;
      bvh_q          <= bvh_d;
      gobek_q        <= gobek_d;
      bobek_q        <= bobek_d;
      zaman_q        <= zaman_d;
    end
  end

  assign anabellek_istek_o          = istek_q;
  assign anabellek_oku_o            = oku_q;
  assign anabellek_yaz_o            = yaz_q;
  assign anabellek_adres_o          = adres_q;
  assign anabellek_yazilacak_obek_o = yobek_q;
  assign getir_veri_hazir_o         = gvh_q;
  assign getir_obek_o               = gobek_q;
  assign bellek_veri_hazir_o        = bvh_q;
  assign bellek_obek_o              = bobek_q;
  assign zaman_asimi_o              = zaman_q;

endmodule

// File: tb/tb_anabellek_hakemi.sv
// Bench for anabellek_hakemi: directed vector table, timeout/reset sequences, then random traffic
// checked against a transaction-level model of the two requesters and the fairness pointer.
module tb_anabellek_hakemi;
  localparam int AB = 32;
  localparam int OB = 128;
  localparam int ZA = 8;
  localparam bit ADIL_P = 1'b1;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          getir_istek_i;
  logic [AB-1:0] getir_adres_i;
  logic          getir_musait_o;
  logic          getir_veri_hazir_o;
  logic [OB-1:0] getir_obek_o;
  logic          bellek_istek_i;
  logic          bellek_yaz_i;
  logic [AB-1:0] bellek_adres_i;
  logic [OB-1:0] bellek_yazilacak_obek_i;
  logic          bellek_musait_o;
  logic          bellek_veri_hazir_o;
  logic [OB-1:0] bellek_obek_o;
  logic          anabellek_musait_i;
  logic          anabellek_veri_hazir_i;
  logic [OB-1:0] anabellek_obek_i;
  logic          anabellek_istek_o;
  logic          anabellek_oku_o;
  logic          anabellek_yaz_o;
  logic [AB-1:0] anabellek_adres_o;
  logic [OB-1:0] anabellek_yazilacak_obek_o;
  logic          zaman_asimi_o;

  anabellek_hakemi #(
    .ADRES_BIT(AB), .OBEK_BIT(OB), .ADIL(ADIL_P), .ZAMAN_ASIMI(ZA)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .getir_istek_i(getir_istek_i), .getir_adres_i(getir_adres_i),
    .getir_musait_o(getir_musait_o), .getir_veri_hazir_o(getir_veri_hazir_o),
    .getir_obek_o(getir_obek_o),
    .bellek_istek_i(bellek_istek_i), .bellek_yaz_i(bellek_yaz_i),
    .bellek_adres_i(bellek_adres_i), .bellek_yazilacak_obek_i(bellek_yazilacak_obek_i),
    .bellek_musait_o(bellek_musait_o), .bellek_veri_hazir_o(bellek_veri_hazir_o),
    .bellek_obek_o(bellek_obek_o),
    .anabellek_musait_i(anabellek_musait_i), .anabellek_veri_hazir_i(anabellek_veri_hazir_i),
    .anabellek_obek_i(anabellek_obek_i),
    .anabellek_istek_o(anabellek_istek_o), .anabellek_oku_o(anabellek_oku_o),
    .anabellek_yaz_o(anabellek_yaz_o), .anabellek_adres_o(anabellek_adres_o),
    .anabellek_yazilacak_obek_o(anabellek_yazilacak_obek_o),
    .zaman_asimi_o(zaman_asimi_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Model: pending requests with their held operands, who was granted last, what each side last received.
  bit            last_b;
  bit            g_pend, b_pend, b_yaz_m, zaman_m;
  logic [AB-1:0] g_addr_m, b_addr_m;
  logic [OB-1:0] b_wdata_m, g_seen, b_seen;

  typedef struct {
    bit            new_g;
    bit            new_b;
    bit            b_yaz;
    logic [AB-1:0] g_addr;
    logic [AB-1:0] b_addr;
    logic [OB-1:0] wdata;
    logic [OB-1:0] rdata;
    int            stall;
    int            delay;
    bit            exp_b;
  } vec_t;
  vec_t tbl [7];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chka(input string name, input logic [AB-1:0] act, input logic [AB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [OB-1:0] act, input logic [OB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [OB-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // With both asking, bellek goes first unless fairness gives getir its turn.
  function automatic bit wins_b(input bit g_req, input bit b_req);
    bit bellek_turn;
    bellek_turn = ADIL_P ? !last_b : 1'b1;
    if (!b_req) return 1'b0;
    if (!g_req) return 1'b1;
    return bellek_turn;
  endfunction

  task automatic drive_reqs();
    getir_istek_i           = g_pend;
    getir_adres_i           = g_addr_m;
    bellek_istek_i          = b_pend;
    bellek_yaz_i            = b_yaz_m;
    bellek_adres_i          = b_addr_m;
    bellek_yazilacak_obek_i = b_wdata_m;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_istek"}, anabellek_istek_o, 1'b0);
    chk1({tag, "_oku"}, anabellek_oku_o, 1'b0);
    chk1({tag, "_yaz"}, anabellek_yaz_o, 1'b0);
    chka({tag, "_adres"}, anabellek_adres_o, '0);
    chkw({tag, "_yobek"}, anabellek_yazilacak_obek_o, '0);
    chk1({tag, "_gvh"}, getir_veri_hazir_o, 1'b0);
    chk1({tag, "_bvh"}, bellek_veri_hazir_o, 1'b0);
    chkw({tag, "_gobek"}, getir_obek_o, '0);
    chkw({tag, "_bobek"}, bellek_obek_o, '0);
    chk1({tag, "_gmusait"}, getir_musait_o, 1'b0);
    chk1({tag, "_bmusait"}, bellek_musait_o, 1'b0);
    chk1({tag, "_zaman"}, zaman_asimi_o, 1'b0);
  endtask

  // Entered just after an edge with the DUT idle; returns just after the edge into the strobe cycle.
  task automatic start_txn(input int stall, input bit exp_b);
    drive_reqs();
    for (int i = 0; i < stall; i++) begin
      anabellek_musait_i     = 1'b0;
      anabellek_veri_hazir_i = ($urandom_range(0, 1) == 1);
      #1;
      chk1("stall_gmusait", getir_musait_o, 1'b0);
      chk1("stall_bmusait", bellek_musait_o, 1'b0);
      @(posedge clk_i); #1;
      chk1("stall_istek", anabellek_istek_o, 1'b0);
    end
    anabellek_musait_i     = 1'b1;
    anabellek_veri_hazir_i = ($urandom_range(0, 1) == 1);
    #1;
    chk1("gmusait", getir_musait_o, !wins_b(1'b1, b_pend));
    chk1("bmusait", bellek_musait_o, wins_b(g_pend, 1'b1));
    @(posedge clk_i); #1;
    last_b = exp_b;
    chk1("istek_strobe", anabellek_istek_o, 1'b1);
    chk1("oku", anabellek_oku_o, exp_b ? !b_yaz_m : 1'b1);
    chk1("yaz", anabellek_yaz_o, exp_b && b_yaz_m);
    chka("adres", anabellek_adres_o, exp_b ? b_addr_m : g_addr_m);
    if (exp_b && b_yaz_m) chkw("yaz_obek", anabellek_yazilacak_obek_o, b_wdata_m);
    chk1("istek_gmusait", getir_musait_o, 1'b0);
    chk1("istek_bmusait", bellek_musait_o, 1'b0);
    chk1("istek_gvh", getir_veri_hazir_o, 1'b0);
    chk1("istek_bvh", bellek_veri_hazir_o, 1'b0);
    anabellek_veri_hazir_i = ($urandom_range(0, 1) == 1);
  endtask

  task automatic serve(input int stall, input int delay, input logic [OB-1:0] rdata, input bit exp_b);
    logic [AB-1:0] a_exp;
    string         who;
    a_exp = exp_b ? b_addr_m : g_addr_m;
    who   = exp_b ? "bellek" : "getir";
    start_txn(stall, exp_b);
    @(posedge clk_i); #1;
    for (int k = 0; k < delay; k++) begin
      anabellek_veri_hazir_i = 1'b0;
      chk1("bekle_istek", anabellek_istek_o, 1'b0);
      chka("bekle_adres", anabellek_adres_o, a_exp);
      chk1("bekle_gvh", getir_veri_hazir_o, 1'b0);
      chk1("bekle_bvh", bellek_veri_hazir_o, 1'b0);
      @(posedge clk_i); #1;
    end
    anabellek_veri_hazir_i = 1'b1;
    anabellek_obek_i       = rdata;
    @(posedge clk_i); #1;
    anabellek_veri_hazir_i = 1'b0;
    anabellek_obek_i       = rnd_blk();
    chk1("zaman", zaman_asimi_o, zaman_m);
    if (exp_b) begin
      chk1("bvh_pulse", bellek_veri_hazir_o, 1'b1);
      chk1("gvh_quiet", getir_veri_hazir_o, 1'b0);
      chkw("bobek", bellek_obek_o, rdata);
      chkw("gobek_hold", getir_obek_o, g_seen);
      b_seen = rdata;
      b_pend = 1'b0;
    end else begin
      chk1("gvh_pulse", getir_veri_hazir_o, 1'b1);
      chk1("bvh_quiet", bellek_veri_hazir_o, 1'b0);
      chkw("gobek", getir_obek_o, rdata);
      chkw("bobek_hold", bellek_obek_o, b_seen);
      g_seen = rdata;
      g_pend = 1'b0;
    end
    drive_reqs();
    $display("txn %s adres=%h delay=%0d stall=%0d data=%h", who, a_exp, delay, stall, rdata);
  endtask

  task automatic model_reset();
    last_b = 1'b0; g_pend = 1'b0; b_pend = 1'b0; zaman_m = 1'b0;
    g_seen = '0; b_seen = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 1, 0, 32'h0000_3000, 32'h0000_4000, '0, {4{32'hC0DE_0001}}, 0, 2, 1};
    tbl[1] = '{0, 1, 1, '0, 32'h0000_2040, {4{32'h1234_5678}}, {4{32'hB0B0_0002}}, 0, 1, 0};
    tbl[2] = '{0, 0, 0, '0, '0, '0, {4{32'hD00D_0003}}, 1, 0, 1};
    tbl[3] = '{1, 0, 0, 32'h0000_1000, '0, '0, {32{4'hA}}, 10, 3, 0};
    tbl[4] = '{1, 1, 0, 32'h0000_5000, 32'h0000_6000, '0, {4{32'h5555_0004}}, 0, ZA - 1, 1};
    tbl[5] = '{0, 0, 0, '0, '0, '0, {4{32'h6666_0005}}, 2, 5, 0};
    tbl[6] = '{0, 1, 0, '0, 32'h0000_7000, '0, {4{32'h7777_0006}}, 0, 0, 1};

    model_reset();
    g_addr_m = '0; b_addr_m = '0; b_yaz_m = 1'b0; b_wdata_m = '0;
    rst_i = 1'b0;
    drive_reqs();
    getir_istek_i = 1'b1; bellek_istek_i = 1'b1;
    anabellek_musait_i = 1'b1; anabellek_veri_hazir_i = 1'b0; anabellek_obek_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_all_zero("reset");
    drive_reqs();
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk1("idle_gmusait", getir_musait_o, 1'b1);
    chk1("idle_bmusait", bellek_musait_o, 1'b1);
    chk1("idle_istek", anabellek_istek_o, 1'b0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].new_g) begin
        g_pend = 1'b1; g_addr_m = tbl[i].g_addr;
      end
      if (tbl[i].new_b) begin
        b_pend = 1'b1; b_yaz_m = tbl[i].b_yaz; b_addr_m = tbl[i].b_addr; b_wdata_m = tbl[i].wdata;
      end
      serve(tbl[i].stall, tbl[i].delay, tbl[i].rdata, tbl[i].exp_b);
    end

    // Memory never answers: getir gets a zero block after ZA wait cycles and the flag sticks.
    g_pend = 1'b1; g_addr_m = 32'h0000_8000;
    start_txn(0, 1'b0);
    @(posedge clk_i); #1;
    anabellek_veri_hazir_i = 1'b0;
    for (int k = 0; k < ZA; k++) begin
      chk1("to_wait_gvh", getir_veri_hazir_o, 1'b0);
      chk1("to_wait_zaman", zaman_asimi_o, 1'b0);
      @(posedge clk_i); #1;
    end
    chk1("to_gvh", getir_veri_hazir_o, 1'b1);
    chk1("to_bvh", bellek_veri_hazir_o, 1'b0);
    chkw("to_gobek", getir_obek_o, '0);
    chk1("to_zaman", zaman_asimi_o, 1'b1);
    $display("txn getir timeout adres=%h", g_addr_m);
    g_seen = '0; g_pend = 1'b0; zaman_m = 1'b1;
    drive_reqs();
    @(posedge clk_i); #1;
    chk1("to_gvh_once", getir_veri_hazir_o, 1'b0);
    chk1("to_sticky", zaman_asimi_o, 1'b1);
    b_pend = 1'b1; b_yaz_m = 1'b1; b_addr_m = 32'h0000_9000; b_wdata_m = rnd_blk();
    serve(0, 2, rnd_blk(), 1'b1);

    // Reset while waiting for memory: everything drops at once, a late response is ignored.
    g_pend = 1'b1; g_addr_m = 32'h0000_A000;
    start_txn(0, 1'b0);
    @(posedge clk_i); #1;
    anabellek_veri_hazir_i = 1'b0;
    @(posedge clk_i); #3;
    rst_i = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    drive_reqs();
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;
    anabellek_veri_hazir_i = 1'b1; anabellek_obek_i = rnd_blk();
    @(posedge clk_i); #1;
    anabellek_veri_hazir_i = 1'b0;
    chk1("late_gvh", getir_veri_hazir_o, 1'b0);
    chk1("late_bvh", bellek_veri_hazir_o, 1'b0);
    chk1("late_istek", anabellek_istek_o, 1'b0);
    @(posedge clk_i); #1;
    chkw("late_gobek", getir_obek_o, '0);
    chk1("late_zaman", zaman_asimi_o, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if (!g_pend && ($urandom_range(0, 1) == 1)) begin
        g_pend = 1'b1; g_addr_m = $urandom;
      end
      if (!b_pend && ($urandom_range(0, 1) == 1)) begin
        b_pend = 1'b1; b_yaz_m = ($urandom_range(0, 1) == 1);
        b_addr_m = $urandom; b_wdata_m = rnd_blk();
      end
      if (!g_pend && !b_pend) begin
        g_pend = 1'b1; g_addr_m = $urandom;
      end
      serve($urandom_range(0, 2), $urandom_range(0, ZA - 1), rnd_blk(), wins_b(g_pend, b_pend));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
